// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// The fill byte doubles as the processor's NOP encoding.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_e;

    localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/imem_loader.sv
// Streams a program image into byte-addressed instruction memory, zero-fills the
// remainder, and holds the processor until a complete, word-aligned image is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_BYTES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic                hs;
    logic [ADDR_W:0]     next_count;

    // start suppresses ready so a restart can never also consume a byte
    assign in_ready   = (state_q == LOAD) && !start;
    assign hs         = in_valid && in_ready;
    assign next_count = byte_count + (ADDR_W+1)'(1);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (hs) begin
                    if (in_last) begin
                        if (next_count[1:0] != 2'b00)    state_d = ERROR;
                        else if (next_count == FULL_COUNT) state_d = RUN;
                        else                               state_d = FILL;
                    end else if (next_count == FULL_COUNT) begin
                        state_d = ERROR;
                    end
                end
            end
            FILL:    if (ptr_q == LAST_ADDR) state_d = RUN;
            default: ;
        endcase
        if (start) state_d = LOAD;
    end

    // NOTE: all state uses non-blocking assignments under an asynchronous reset so
    // outputs drop the moment rst_n falls; instruction memory itself is never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            byte_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_run    <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_we  <= 1'b0;
            // run is released one cycle after entering RUN so the last write settles first
            cpu_run <= (state_q == RUN) && (state_d == RUN);
            error   <= (state_d == ERROR);

            if (start || state_q == IDLE) begin
                ptr_q      <= '0;
                byte_count <= '0;
            end else if (hs) begin
                mem_we     <= 1'b1;
                mem_addr   <= ptr_q;
                mem_wdata  <= in_data;
                byte_count <= next_count;
                if (ptr_q != LAST_ADDR) ptr_q <= ptr_q + ADDR_W'(1);
            end else if (state_q == FILL) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr_q;
                mem_wdata <= FILL_BYTE;
                if (ptr_q != LAST_ADDR) ptr_q <= ptr_q + ADDR_W'(1);
            end
        end
    end

endmodule
